status_reg: RTL
===============

# status_reg

Processor status register (P) for the hmc-6502 core, directly downstream of the ALU. It latches the ALU's zero, negative, overflow and carry-out flags under per-flag update enables from the controller. It also executes flag instructions (SEC/CLC/SEI/CLI/SED/CLD/CLV), loads P from the data bus for PLP/RTI, and formats P for PHP/BRK pushes. It feeds carry and decimal mode back to the ALU (`c_in`, `bcd`), and supplies a one-instruction-delayed IRQ mask to the interrupt logic.

## Interface
Parameters:
- `RESET_I`, 1: value of I after reset.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `alu_zero`, `alu_negative`, `alu_overflow`, `alu_c_out` in 1 each: ALU flag outputs for the current cycle.
- `upd_c`, `upd_z`, `upd_n`, `upd_v` in 1 each: capture the corresponding ALU flag this cycle.
- `bit_mode` in 1: BIT instruction; V is taken from `mem_b6` instead of `alu_overflow`.
- `mem_b6` in 1: operand bit 6 for BIT.
- `flag_op` in 3: flag instruction code (package enum): NONE, SEC, CLC, SEI, CLI, SED, CLD, CLV.
- `p_load` in 1: load P from `p_in` (PLP/RTI).
- `p_in` in 8: data-bus value for `p_load`.
- `push_brk` in 1: B bit value for `p_push` (1 = PHP/BRK, 0 = IRQ/NMI).
- `inst_done` in 1: instruction boundary strobe from the controller.
- `p_out` out 8: {N,V,1,1,D,I,Z,C}; debug/observation.
- `p_push` out 8: {N,V,1,push_brk,D,I,Z,C}; combinational; for stack writes.
- `c_flag` out 1: registered C; drives ALU `c_in`.
- `bcd` out 1: registered D; drives ALU `bcd`.
- `irq_mask` out 1: delayed effective I.

## Operation
- State: six flag flops (N, V, D, I, Z, C) and `irq_mask` flop. B and bit 5 are not stored.
- Reset (edge with `reset`=1): N=V=D=Z=C=0, I=`RESET_I`, `irq_mask`=`RESET_I`. With default parameter, `p_out`=8'h34. Reset overrides all other inputs.
- Priority per flag, highest first:
  1. `reset`
  2. `p_load`: all six flags from `p_in` bits 7,6,3,2,1,0; `p_in[5:4]` ignored.
  3. `flag_op` targeting that flag.
  4. `upd_*`
  5. Hold.
- `upd_v` with `bit_mode`=1: V←`mem_b6`; otherwise V←`alu_overflow`. `bit_mode` with `upd_v`=0 has no effect.
- `flag_op` touches only its flag. Other flags may update from `upd_*` in the same cycle. Example: CLC plus `upd_z` → C=0, Z←`alu_zero`.
- Illegal `flag_op` encodings act as NONE.
- `irq_mask`: on edge with `inst_done`=1, `irq_mask`←current registered I (pre-edge value). Otherwise hold. This gives CLI/SEI/PLP effect one instruction late, as on the NMOS 6502.

## Timing
- All flag updates are visible on `p_out`/`c_flag`/`bcd` the cycle after the controls are asserted (1-cycle latency). No combinational path from `alu_*` to any output.
- `p_push` is combinational from registered flags and `push_brk` only.
- `c_flag` is registered, so an ALU op in cycle N sees carry produced in cycle N-1 or earlier. This is a required ALU/controller contract for multi-byte arithmetic.
- `inst_done` and a CLI `flag_op` in the same cycle: I←0 at the edge, `irq_mask` keeps 1. `irq_mask`←0 at the next `inst_done`.
- Reset asserted mid-instruction: flags reset on that edge regardless of `p_load`/`flag_op`/`upd_*`.
- No handshake; controls are single-cycle qualifiers, re-sampled every edge.

## Structure
- Shared package `core_pkg`:
  - `flag_op_t` enum (NONE=0, SEC, CLC, SEI, CLI, SED, CLD, CLV).
  - Bit-position constants: P_C=0, P_Z=1, P_I=2, P_D=3, P_B=4, P_U=5, P_V=6, P_N=7.
  - Reset constant P_RESET=8'h34.
- No sub-module: six independent flag flops with a priority mux, plus the `irq_mask` flop, all in one module.

## Test plan
- Reset with all inputs toggling → `p_out`=8'h34, `irq_mask`=1, `c_flag`=0, `bcd`=0.
- `alu_c_out`=1, `alu_zero`=1, `upd_c`=`upd_z`=1 → next cycle `p_out`=8'h37. Then SEC with `upd_c`=1, `alu_c_out`=0 → C stays 1.
- `p_load`, `p_in`=8'hFF, with CLC and all `upd_*` high → `p_out`=8'hFF. Then `p_in`=8'h00 → `p_out`=8'h30.
- BIT: `bit_mode`=1, `upd_v`=1, `upd_n`=1, `mem_b6`=1, `alu_overflow`=0, `alu_negative`=1 → V=1, N=1. `p_push` with `push_brk`=0 → 8'hE4 (from I=1 state).
- CLI with `inst_done`=1 → I=0 but `irq_mask`=1. Next `inst_done` → `irq_mask`=0. SEI → `irq_mask`=1 only after the following `inst_done`.
- SED → `bcd`=1 next cycle. `p_load` with `reset` in the same cycle → `p_out`=8'h34.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: definitions shared across the hmc-6502 core.
// Contents:
//   flag_op_t - controller encoding for the single-flag instructions
//               (SEC/CLC/SEI/CLI/SED/CLD/CLV); FLAG_NONE means no flag op.
//   P_*       - bit positions of each flag inside the processor status byte.
//   P_RESET   - status byte as seen right after reset (I set, bits 5/4 high).
package core_pkg;

  typedef enum logic [2:0] {
    FLAG_NONE = 3'd0,
    FLAG_SEC  = 3'd1,
    FLAG_CLC  = 3'd2,
    FLAG_SEI  = 3'd3,
    FLAG_CLI  = 3'd4,
    FLAG_SED  = 3'd5,
    FLAG_CLD  = 3'd6,
    FLAG_CLV  = 3'd7
  } flag_op_t;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [7:0] P_RESET = 8'h34;

endpackage

// File: rtl/status_reg.sv
// status_reg: 6502 processor status register (P), downstream of the ALU.
// Holds the N, V, D, I, Z and C flags plus a delayed IRQ mask. B and bit 5
// are not stored; they are inserted when P is presented.
// Ports:
//   clk, reset             - clock; synchronous active-high reset
//   alu_zero/negative/
//     overflow/c_out       - ALU flag results for this cycle
//   upd_c/z/n/v            - capture the matching ALU flag this cycle
//   bit_mode, mem_b6       - BIT instruction: V comes from operand bit 6
//   flag_op                - flag instruction code (flag_op_t)
//   p_load, p_in           - load all flags from the data bus (PLP/RTI)
//   push_brk               - B bit inserted into p_push
//   inst_done              - instruction boundary strobe
//   p_out                  - {N,V,1,1,D,I,Z,C} for observation
//   p_push                 - {N,V,1,push_brk,D,I,Z,C} for stack writes
//   c_flag, bcd            - registered carry and decimal mode to the ALU
//   irq_mask               - I as it stood at the last instruction boundary
module status_reg
  import core_pkg::*;
#(
  parameter logic RESET_I = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  input  logic       alu_c_out,
  input  logic       upd_c,
  input  logic       upd_z,
  input  logic       upd_n,
  input  logic       upd_v,
  input  logic       bit_mode,
  input  logic       mem_b6,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic [7:0] p_in,
  input  logic       push_brk,
  input  logic       inst_done,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       c_flag,
  output logic       bcd,
  output logic       irq_mask
);

  logic n_q, v_q, d_q, i_q, z_q, c_q, irqMask_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d, irqMask_d;

  // Next-state selection. Assignments are ordered lowest priority first so
  // that later ones win: hold, ALU capture, flag instruction, bus load.
  // Reset is applied in the register block and overrides all of these.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;

    if (upd_n) n_d = alu_negative;
    if (upd_v) v_d = bit_mode ? mem_b6 : alu_overflow;
    if (upd_z) z_d = alu_zero;
    if (upd_c) c_d = alu_c_out;

    // A flag instruction only touches its own flag, so captures of the
    // other flags in the same cycle still take effect.
    case (flag_op_t'(flag_op))
      FLAG_SEC: c_d = 1'b1;
      FLAG_CLC: c_d = 1'b0;
      FLAG_SEI: i_d = 1'b1;
      FLAG_CLI: i_d = 1'b0;
      FLAG_SED: d_d = 1'b1;
      FLAG_CLD: d_d = 1'b0;
      FLAG_CLV: v_d = 1'b0;
      default:  ;
    endcase

    // Bits 5 and 4 of the bus value have no storage and are dropped.
    if (p_load) begin
      n_d = p_in[P_N];
      v_d = p_in[P_V];
      d_d = p_in[P_D];
      i_d = p_in[P_I];
      z_d = p_in[P_Z];
      c_d = p_in[P_C];
    end

    // The mask samples the pre-edge I, so CLI/SEI/PLP reach the interrupt
    // logic one instruction late, as on the NMOS part.
    irqMask_d = inst_done ? i_q : irqMask_q;
  end

  // Flag and mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q       <= P_RESET[P_N];
      v_q       <= P_RESET[P_V];
      d_q       <= P_RESET[P_D];
      i_q       <= RESET_I;
      z_q       <= P_RESET[P_Z];
      c_q       <= P_RESET[P_C];
      irqMask_q <= RESET_I;
    end else begin
      n_q       <= n_d;
      v_q       <= v_d;
      d_q       <= d_d;
      i_q       <= i_d;
      z_q       <= z_d;
      c_q       <= c_d;
      irqMask_q <= irqMask_d;
    end
  end

  // Status byte presentation: bit 5 always reads 1; B is 1 on the observed
  // value and follows push_brk on the pushed value.
  always_comb begin
    p_out      = 8'h00;
    p_out[P_N] = n_q;
    p_out[P_V] = v_q;
    p_out[P_U] = 1'b1;
    p_out[P_B] = 1'b1;
    p_out[P_D] = d_q;
    p_out[P_I] = i_q;
    p_out[P_Z] = z_q;
    p_out[P_C] = c_q;

    p_push      = p_out;
    p_push[P_B] = push_brk;
  end

  assign c_flag   = c_q;
  assign bcd      = d_q;
  assign irq_mask = irqMask_q;

endmodule
